// File: rtl/sargantana_icache_pkg.sv
// Shared types and default sizing for the non-cacheable instruction fetch buffer.
package sargantana_icache_pkg;

  localparam int unsigned NcNumEntries = 2;
  localparam int unsigned NcLineBits   = 64;
  localparam int unsigned NcAddrBits   = 40;
  localparam int unsigned NcInstBits   = 32;
  localparam int unsigned NcL2DataBits = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } nc_ifetch_state_t;

  // Index width that never collapses to zero bits for single-element ranges.
  function automatic int unsigned nc_idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nc_line_store.sv
// Line storage for the non-cacheable fetch buffer: valid/tag/data arrays,
// single-match lookup and a round-robin victim pointer.
module nc_line_store
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned NumEntries = NcNumEntries,
  parameter int unsigned LineBits   = NcLineBits,
  parameter int unsigned InstBits   = NcInstBits,
  parameter int unsigned TagBits    = NcAddrBits - $clog2(NcLineBits / 8),
  parameter int unsigned WSelBits   = nc_idx_bits(NcLineBits / NcInstBits)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [TagBits-1:0]  lookup_tag,
  input  logic [WSelBits-1:0] word_sel,
  output logic                hit,
  output logic [InstBits-1:0] word,
  input  logic                fill,
  input  logic [TagBits-1:0]  fill_tag,
  input  logic [LineBits-1:0] fill_data,
  input  logic                flush
);

  localparam int unsigned IdxBits = nc_idx_bits(NumEntries);
  localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NumEntries - 1);

  logic [NumEntries-1:0] valid;
  logic [TagBits-1:0]    tags [NumEntries];
  logic [LineBits-1:0]   lines [NumEntries];
  logic [IdxBits-1:0]    victim;
  logic [LineBits-1:0]   hit_line;
  int unsigned           word_base;

  // Fully associative match; fills only happen after a miss, so at most one entry matches.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      if (valid[i] && (tags[i] == lookup_tag)) begin
        hit      = 1'b1;
        hit_line = lines[i];
      end
    end
    word_base = int'(word_sel) * InstBits;
    word      = hit_line[word_base +: InstBits];
  end

  // Valid bits and victim pointer; flush takes priority over a same-cycle fill.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid  <= '0;
      victim <= '0;
    end else if (flush) begin
      valid  <= '0;
      victim <= '0;
    end else if (fill) begin
      valid[victim] <= 1'b1;
      victim        <= (victim == LastIdx) ? '0 : victim + 1'b1;
    end
  end

  // Tag and data payload; contents are only meaningful under a set valid bit.
  always_ff @(posedge clk_i) begin
    if (fill && !flush) begin
      tags[victim]  <= fill_tag;
      lines[victim] <= fill_data;
    end
  end

endmodule

// File: rtl/nc_ifetch_buffer.sv
// Non-cacheable instruction fetch buffer: serves hits from a small line store,
// issues one outstanding L2 line request on a miss, and drains stale responses
// after kill/flush.
module nc_ifetch_buffer
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned NumEntries = NcNumEntries,
  parameter int unsigned LineBits   = NcLineBits,
  parameter int unsigned AddrBits   = NcAddrBits,
  parameter int unsigned InstBits   = NcInstBits,
  parameter int unsigned L2DataBits = NcL2DataBits
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  input  logic [AddrBits-1:0]   req_addr_i,
  output logic                  req_ready_o,
  input  logic                  kill_i,
  input  logic                  flush_i,
  output logic                  l2_req_valid_o,
  output logic [AddrBits-1:0]   l2_req_addr_o,
  input  logic                  l2_req_ready_i,
  input  logic                  l2_resp_valid_i,
  input  logic [L2DataBits-1:0] l2_resp_data_i,
  output logic                  resp_valid_o,
  output logic [InstBits-1:0]   resp_data_o
);

  localparam int unsigned OffBits      = $clog2(LineBits / 8);
  localparam int unsigned InstOffBits  = $clog2(InstBits / 8);
  localparam int unsigned TagBits      = AddrBits - OffBits;
  localparam int unsigned WordsPerLine = LineBits / InstBits;
  localparam int unsigned WSelBits     = nc_idx_bits(WordsPerLine);
  localparam logic [WSelBits-1:0] WSelMask = WSelBits'(WordsPerLine - 1);

  nc_ifetch_state_t state, state_next;

  logic [TagBits-1:0]  req_tag;
  logic [AddrBits-1:0] req_addr_sh;
  logic [WSelBits-1:0] req_wsel;
  logic [TagBits-1:0]  lat_tag;
  logic [WSelBits-1:0] lat_wsel;
  logic                latch_en;

  logic                abort;
  logic                store_hit;
  logic [InstBits-1:0] store_word;
  logic                fill;
  logic [LineBits-1:0] fill_line;
  logic [InstBits-1:0] fill_word;
  int unsigned         fill_base;

  logic                resp_valid_d;
  logic [InstBits-1:0] resp_data_d;

  assign abort       = kill_i | flush_i;
  assign req_tag     = req_addr_i[AddrBits-1:OffBits];
  assign req_addr_sh = req_addr_i >> InstOffBits;
  assign req_wsel    = req_addr_sh[WSelBits-1:0] & WSelMask;
  assign fill_line   = l2_resp_data_i[LineBits-1:0];

  assign l2_req_valid_o = (state == ISSUE);
  assign l2_req_addr_o  = {lat_tag, {OffBits{1'b0}}};

  nc_line_store #(
    .NumEntries (NumEntries),
    .LineBits   (LineBits),
    .InstBits   (InstBits),
    .TagBits    (TagBits),
    .WSelBits   (WSelBits)
  ) u_store (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .lookup_tag (req_tag),
    .word_sel   (req_wsel),
    .hit        (store_hit),
    .word       (store_word),
    .fill       (fill),
    .fill_tag   (lat_tag),
    .fill_data  (fill_line),
    .flush      (flush_i)
  );

  // Select the requested instruction out of the returning L2 line.
  always_comb begin
    fill_base = int'(lat_wsel) * InstBits;
    fill_word = fill_line[fill_base +: InstBits];
  end

  // Next-state and per-state outputs; acceptance is masked by kill/flush.
  always_comb begin
    state_next   = state;
    req_ready_o  = 1'b0;
    latch_en     = 1'b0;
    fill         = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_o;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !abort) begin
          if (store_hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = store_word;
          end else begin
            latch_en   = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          // A request already handshaken still owes a response that must be drained.
          state_next = l2_req_ready_i ? DRAIN : IDLE;
        end else if (l2_req_ready_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (l2_resp_valid_i) begin
          state_next = IDLE;
          if (!abort) begin
            fill         = 1'b1;
            resp_valid_d = 1'b1;
            resp_data_d  = fill_word;
          end
        end else if (abort) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (l2_resp_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  // Miss address latch; holds the request address stable while in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lat_tag  <= '0;
      lat_wsel <= '0;
    end else if (latch_en) begin
      lat_tag  <= req_tag;
      lat_wsel <= req_wsel;
    end
  end

  // Response register; data holds its last value between valid pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      resp_valid_o <= resp_valid_d;
      resp_data_o  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_nc_ifetch_buffer.sv
// Self-checking bench for nc_ifetch_buffer: directed scenarios plus randomized
// fetch traffic against a FIFO-replacement line model.
module tb_nc_ifetch_buffer;

  localparam int unsigned NE  = 2;
  localparam int unsigned LB  = 64;
  localparam int unsigned AB  = 40;
  localparam int unsigned IB  = 32;
  localparam int unsigned L2B = 256;
  localparam int unsigned TB  = AB - 3;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           req_valid = 1'b0;
  logic [AB-1:0]  req_addr = '0;
  logic           req_ready;
  logic           kill = 1'b0;
  logic           flush = 1'b0;
  logic           l2_req_valid;
  logic [AB-1:0]  l2_req_addr;
  logic           l2_req_ready = 1'b0;
  logic           l2_resp_valid = 1'b0;
  logic [L2B-1:0] l2_resp_data = '0;
  logic           resp_valid;
  logic [IB-1:0]  resp_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [L2B-1:0] mem [logic [TB-1:0]];
  logic [TB-1:0]  model_q [$];

  always #5 clk = ~clk;

  nc_ifetch_buffer #(
    .NumEntries (NE),
    .LineBits   (LB),
    .AddrBits   (AB),
    .InstBits   (IB),
    .L2DataBits (L2B)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .req_ready_o     (req_ready),
    .kill_i          (kill),
    .flush_i         (flush),
    .l2_req_valid_o  (l2_req_valid),
    .l2_req_addr_o   (l2_req_addr),
    .l2_req_ready_i  (l2_req_ready),
    .l2_resp_valid_i (l2_resp_valid),
    .l2_resp_data_i  (l2_resp_data),
    .resp_valid_o    (resp_valid),
    .resp_data_o     (resp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [L2B-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [L2B-1:0] get_line(input logic [TB-1:0] tag);
    if (!mem.exists(tag)) mem[tag] = rand_line();
    return mem[tag];
  endfunction

  function automatic bit model_has(input logic [TB-1:0] tag);
    foreach (model_q[i]) if (model_q[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Round-robin victim over fills with flush resetting both pointer and valids
  // evicts exactly in fill order, so a bounded FIFO of tags describes it.
  function automatic void model_fill(input logic [TB-1:0] tag);
    if (model_q.size() == NE) void'(model_q.pop_front());
    model_q.push_back(tag);
  endfunction

  function automatic void model_flush();
    model_q.delete();
  endfunction

  // mode: 0 normal, 1 kill in ISSUE (no ready), 2 kill in WAIT, 3 flush with
  // response, 4 kill with response, 5 kill with request, 6 flush with request.
  // hold < 0 picks a random L2 ready delay.
  task automatic fetch(input logic [AB-1:0] addr, input int mode, input int hold, output bit was_hit);
    logic [TB-1:0]  tag;
    logic [L2B-1:0] line;
    logic [IB-1:0]  exp_word;
    int             wsel;
    int             nhold;
    bit             exp_hit;
    tag      = addr[AB-1:3];
    line     = get_line(tag);
    wsel     = int'(addr % (LB / 8)) / (IB / 8);
    exp_word = line[wsel*IB +: IB];
    exp_hit  = model_has(tag);
    nhold    = (hold < 0) ? int'($urandom_range(0, 3)) : hold;

    check("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    kill      = (mode == 5);
    flush     = (mode == 6);
    @(negedge clk);
    req_valid = 1'b0;
    kill      = 1'b0;
    flush     = 1'b0;
    was_hit   = resp_valid;

    if (mode == 5 || mode == 6) begin
      check("masked_resp", resp_valid, 0);
      check("masked_l2req", l2_req_valid, 0);
      check("masked_ready", req_ready, 1);
      if (mode == 6) model_flush();
      return;
    end

    if (exp_hit) begin
      check("hit_valid", resp_valid, 1);
      check("hit_data", resp_data, exp_word);
      check("hit_no_l2", l2_req_valid, 0);
      @(negedge clk);
      check("hit_pulse", resp_valid, 0);
      check("hit_hold", resp_data, exp_word);
      return;
    end

    check("miss_no_resp", resp_valid, 0);
    check("l2_valid", l2_req_valid, 1);
    check("l2_addr", l2_req_addr, {tag, 3'b000});
    check("ready_issue", req_ready, 0);

    if (mode == 1) begin
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("retract_valid", l2_req_valid, 0);
      check("retract_ready", req_ready, 1);
      return;
    end

    for (int i = 0; i < nhold; i++) begin
      @(negedge clk);
      check("hold_valid", l2_req_valid, 1);
      check("hold_addr", l2_req_addr, {tag, 3'b000});
      check("hold_ready", req_ready, 0);
    end
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    check("wait_no_l2", l2_req_valid, 0);
    check("ready_wait", req_ready, 0);

    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("wait_no_resp", resp_valid, 0);
    end
    if (mode == 2) begin
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("ready_drain", req_ready, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    l2_resp_valid = 1'b1;
    l2_resp_data  = line;
    flush         = (mode == 3);
    kill          = (mode == 4);
    @(negedge clk);
    l2_resp_valid = 1'b0;
    l2_resp_data  = rand_line();
    flush         = 1'b0;
    kill          = 1'b0;
    check("ready_after", req_ready, 1);
    if (mode == 0) begin
      check("fill_valid", resp_valid, 1);
      check("fill_data", resp_data, exp_word);
      model_fill(tag);
      @(negedge clk);
      check("fill_pulse", resp_valid, 0);
      check("fill_hold", resp_data, exp_word);
    end else begin
      check("dropped_resp", resp_valid, 0);
      if (mode == 3) model_flush();
    end
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
    check("flush_ready", req_ready, 1);
  endtask

  logic [AB-1:0] pool [6];

  initial begin
    bit            h;
    logic [AB-1:0] a;
    int            r;
    int            mode;

    pool[0] = 40'h00_0001_0000;
    pool[1] = 40'h00_0001_0008;
    pool[2] = 40'h00_0001_0010;
    pool[3] = 40'h00_8000_0040;
    pool[4] = 40'hFF_FFFF_FFF8;
    pool[5] = 40'h00_0000_0000;

    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_l2_valid", l2_req_valid, 0);
    check("rst_l2_addr", l2_req_addr, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Cold miss then hit on the other word of the same line.
    a = 40'h00_0001_0004;
    mem[a[AB-1:3]] = {rand_line() >> 64, 64'hAAAA_BBBB_CCCC_DDDD};
    fetch(a, 0, 2, h);
    check("cold_miss", h, 0);
    check("cold_word", resp_data, 32'hAAAA_BBBB);
    fetch(40'h00_0001_0000, 0, 0, h);
    check("refetch_hit", h, 1);
    check("refetch_word", resp_data, 32'hCCCC_DDDD);

    // Round-robin eviction: C replaces A, B survives.
    idle_flush();
    fetch(40'h00_0002_0000, 0, 0, h);
    fetch(40'h00_0002_0008, 0, 0, h);
    fetch(40'h00_0002_0010, 0, 0, h);
    fetch(40'h00_0002_0008, 0, 0, h);
    check("evict_b_hit", h, 1);
    fetch(40'h00_0002_0000, 0, 0, h);
    check("evict_a_miss", h, 0);

    // Five-cycle L2 backpressure.
    fetch(40'h00_0003_0000, 0, 5, h);
    check("stall_miss", h, 0);

    // Kill in WAIT drains the response without a fill.
    fetch(40'h00_0004_0000, 2, 0, h);
    fetch(40'h00_0004_0000, 0, 0, h);
    check("kill_no_fill", h, 0);

    // Flush coincident with the response.
    fetch(40'h00_0005_0000, 3, 1, h);
    fetch(40'h00_0005_0000, 0, 0, h);
    check("flush_no_fill", h, 0);

    // Reset asserted while waiting for the L2 response.
    req_valid = 1'b1;
    req_addr  = 40'h00_0006_0000;
    @(negedge clk);
    req_valid = 1'b0;
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_l2_valid", l2_req_valid, 0);
    check("mid_rst_l2_addr", l2_req_addr, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_data", resp_data, 0);
    model_flush();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    l2_resp_valid = 1'b1;
    l2_resp_data  = get_line(40'h00_0006_0000 >> 3);
    @(negedge clk);
    l2_resp_valid = 1'b0;
    check("late_resp_ignored", resp_valid, 0);
    check("late_resp_ready", req_ready, 1);
    fetch(40'h00_0005_0000, 0, 0, h);
    check("rst_invalidated", h, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      a = pool[$urandom_range(0, 5)] | (($urandom_range(0, 1) != 0) ? 40'h4 : 40'h0);
      r = int'($urandom_range(0, 15));
      if (r <= 8)       mode = 0;
      else if (r <= 14) mode = r - 8;
      else              mode = -1;
      if (mode < 0) idle_flush();
      else          fetch(a, mode, -1, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
